control_unit: RTL and testbench

- Main decoder and ALU decoder for a single-cycle RV32I core; sits between the instruction memory output and the datapath.
- Decodes the 32-bit instruction and the ALU flags into PC-select, writeback-select, memory/register write enables, ALU operation and immediate format.
- Decode is combinational; a one-bit synchronous "active" register forces safe outputs during and right after reset.

---
 rtl/control_unit.sv | 148 ++++++++++++++
 tb/tb_control_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// Main decoder and ALU decoder for a single-cycle RV32I core.
// Decode is combinational, and outputs are held at zero until the first clock edge after reset.
module control_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic        Zero,
  input  logic        Negative,
  output logic [1:0]  PCSrc,
  output logic [1:0]  ResultSrc,
  output logic        MemWrite,
  output logic        ALUSrc,
  output logic        RegWrite,
  output logic [4:0]  ALUControl,
  output logic [2:0]  ImmSrc
);

  localparam int unsigned OP_W  = 7;
  localparam int unsigned ALU_W = 5;

  localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OP_W-1:0] OP_IALU   = 7'b0010011;
  localparam logic [OP_W-1:0] OP_RTYPE  = 7'b0110011;
  localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OP_W-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OP_W-1:0] OP_LUI    = 7'b0110111;

  localparam logic [ALU_W-1:0] ALU_ADD  = 5'd0;
  localparam logic [ALU_W-1:0] ALU_SUB  = 5'd1;
  localparam logic [ALU_W-1:0] ALU_AND  = 5'd2;
  localparam logic [ALU_W-1:0] ALU_OR   = 5'd3;
  localparam logic [ALU_W-1:0] ALU_XOR  = 5'd4;
  localparam logic [ALU_W-1:0] ALU_SLT  = 5'd5;
  localparam logic [ALU_W-1:0] ALU_SLTU = 5'd6;
  localparam logic [ALU_W-1:0] ALU_SLL  = 5'd7;
  localparam logic [ALU_W-1:0] ALU_SRL  = 5'd8;
  localparam logic [ALU_W-1:0] ALU_SRA  = 5'd9;

  logic            active;
  logic [OP_W-1:0] op;
  logic [2:0]      f3;
  logic            f7b5;
  logic [ALU_W-1:0] arith_alu;
  logic            taken;
  logic            unused_instr_bits;

  assign op   = Instr[6:0];
  assign f3   = Instr[14:12];
  assign f7b5 = Instr[30];
  assign unused_instr_bits = ^{Instr[31], Instr[29:15], Instr[11:7]};

  // Cleared by reset, set on the first edge with reset low.
  always_ff @(posedge clk) begin
    if (reset) active <= 1'b0;
    else       active <= 1'b1;
  end

  // Shared R-type / I-ALU operation table; only R-type uses bit 30 for SUB.
  always_comb begin
    arith_alu = ALU_ADD;
    case (f3)
      3'b000:  arith_alu = (f7b5 && (op == OP_RTYPE)) ? ALU_SUB : ALU_ADD;
      3'b001:  arith_alu = ALU_SLL;
      3'b010:  arith_alu = ALU_SLT;
      3'b011:  arith_alu = ALU_SLTU;
      3'b100:  arith_alu = ALU_XOR;
      3'b101:  arith_alu = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  arith_alu = ALU_OR;
      3'b111:  arith_alu = ALU_AND;
      default: arith_alu = ALU_ADD;
    endcase
  end

  // Branch condition from ALU flags; bltu/bgeu rely on the SLTU result.
  always_comb begin
    taken = 1'b0;
    case (f3)
      3'b000:  taken = Zero;
      3'b001:  taken = !Zero;
      3'b100:  taken = Negative;
      3'b101:  taken = !Negative;
      3'b110:  taken = !Zero;
      3'b111:  taken = Zero;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    PCSrc      = 2'b00;
    ResultSrc  = 2'b00;
    MemWrite   = 1'b0;
    ALUSrc     = 1'b0;
    RegWrite   = 1'b0;
    ALUControl = ALU_ADD;
    ImmSrc     = 3'b000;
    if (active) begin
      case (op)
        OP_LOAD: begin
          RegWrite  = 1'b1;
          ALUSrc    = 1'b1;
          ResultSrc = 2'b01;
        end
        OP_STORE: begin
          ALUSrc   = 1'b1;
          MemWrite = 1'b1;
          ImmSrc   = 3'b001;
        end
        OP_IALU: begin
          RegWrite   = 1'b1;
          ALUSrc     = 1'b1;
          ALUControl = arith_alu;
        end
        OP_RTYPE: begin
          RegWrite   = 1'b1;
          ALUControl = arith_alu;
        end
        OP_BRANCH: begin
          ImmSrc     = 3'b010;
          ALUControl = (f3[2:1] == 2'b11) ? ALU_SLTU : ALU_SUB;
          PCSrc      = taken ? 2'b01 : 2'b00;
        end
        OP_JAL: begin
          RegWrite  = 1'b1;
          ResultSrc = 2'b10;
          ImmSrc    = 3'b011;
          PCSrc     = 2'b01;
        end
        OP_JALR: begin
          RegWrite  = 1'b1;
          ALUSrc    = 1'b1;
          ResultSrc = 2'b10;
          PCSrc     = 2'b10;
        end
        OP_LUI: begin
          RegWrite  = 1'b1;
          ResultSrc = 2'b11;
          ImmSrc    = 3'b100;
        end
        default: begin
          PCSrc = 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed vectors plus randomized instructions
// checked against a table-driven reference model.
module tb_control_unit;

  logic        clk;
  logic        reset;
  logic [31:0] Instr;
  logic        Zero;
  logic        Negative;
  logic [1:0]  PCSrc;
  logic [1:0]  ResultSrc;
  logic        MemWrite;
  logic        ALUSrc;
  logic        RegWrite;
  logic [4:0]  ALUControl;
  logic [2:0]  ImmSrc;

  int errors = 0;
  int checks = 0;

  control_unit dut (
    .clk(clk), .reset(reset), .Instr(Instr), .Zero(Zero), .Negative(Negative),
    .PCSrc(PCSrc), .ResultSrc(ResultSrc), .MemWrite(MemWrite), .ALUSrc(ALUSrc),
    .RegWrite(RegWrite), .ALUControl(ALUControl), .ImmSrc(ImmSrc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU operation for f3 = 0..7 (index 7 is leftmost); SUB/SRA are ADD/SRL plus one.
  localparam logic [7:0][4:0] ALU_TAB = {5'd2, 5'd3, 5'd8, 5'd4, 5'd6, 5'd5, 5'd7, 5'd0};

  typedef struct {
    logic [31:0] ins;
    logic        z;
    logic        n;
    logic [14:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [14:0] vec(input logic [1:0] pc, input logic [1:0] rs,
                                      input logic mw, input logic asrc, input logic rw,
                                      input logic [4:0] alu, input logic [2:0] imm);
    return {pc, rs, mw, asrc, rw, alu, imm};
  endfunction

  function automatic logic [14:0] observed();
    return {PCSrc, ResultSrc, MemWrite, ALUSrc, RegWrite, ALUControl, ImmSrc};
  endfunction

  function automatic logic [14:0] model(input logic [6:0] op, input logic [2:0] f3,
                                        input logic f7b5, input logic z, input logic n);
    logic [4:0] alu;
    logic       tk;
    alu = ALU_TAB[f3];
    if (f3 == 3'd5) alu = alu + 5'(f7b5);
    case (f3)
      3'd0: tk = z;
      3'd1: tk = !z;
      3'd4: tk = n;
      3'd5: tk = !n;
      3'd6: tk = !z;
      3'd7: tk = z;
      default: tk = 1'b0;
    endcase
    case (op)
      7'b0000011: return vec(2'b00, 2'b01, 1'b0, 1'b1, 1'b1, 5'd0, 3'b000);
      7'b0100011: return vec(2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 5'd0, 3'b001);
      7'b0010011: return vec(2'b00, 2'b00, 1'b0, 1'b1, 1'b1, alu, 3'b000);
      7'b0110011: return vec(2'b00, 2'b00, 1'b0, 1'b0, 1'b1,
                             (f3 == 3'd0) ? 5'(f7b5) : alu, 3'b000);
      7'b1100011: return vec(tk ? 2'b01 : 2'b00, 2'b00, 1'b0, 1'b0, 1'b0,
                             (f3 >= 3'd6) ? 5'd6 : 5'd1, 3'b010);
      7'b1101111: return vec(2'b01, 2'b10, 1'b0, 1'b0, 1'b1, 5'd0, 3'b011);
      7'b1100111: return vec(2'b10, 2'b10, 1'b0, 1'b1, 1'b1, 5'd0, 3'b000);
      7'b0110111: return vec(2'b00, 2'b11, 1'b0, 1'b0, 1'b1, 5'd0, 3'b100);
      default:    return 15'd0;
    endcase
  endfunction

  task automatic test_reset();
    logic [14:0] got;
    reset = 1'b1; Instr = 32'h03200093; Zero = 1'b0; Negative = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    got = observed(); checks++;
    if (got !== 15'd0) begin
      errors++; $display("FAIL reset_held: got %h expected %h", got, 15'd0);
    end
    reset = 1'b0;
    #1;
    got = observed(); checks++;
    if (got !== 15'd0) begin
      errors++; $display("FAIL reset_release_pre_edge: got %h expected %h", got, 15'd0);
    end
    @(posedge clk); #1;
    got = observed(); checks++;
    if (got !== vec(2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 5'd0, 3'b000)) begin
      errors++; $display("FAIL reset_first_active: got %h expected %h", got,
                         vec(2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 5'd0, 3'b000));
    end
  endtask

  task automatic test_directed();
    logic [14:0] got;
    vecs.delete();
    vecs.push_back('{32'hffc02103, 1'b0, 1'b0, vec(2'b00, 2'b01, 1'b0, 1'b1, 1'b1, 5'd0, 3'b000), "lw"});
    vecs.push_back('{32'h402081b3, 1'b0, 1'b0, vec(2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 5'd1, 3'b000), "sub"});
    vecs.push_back('{32'h002081b3, 1'b1, 1'b1, vec(2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 5'd0, 3'b000), "add"});
    vecs.push_back('{32'hfe302e23, 1'b0, 1'b0, vec(2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 5'd0, 3'b001), "sw"});
    vecs.push_back('{32'h00000063, 1'b1, 1'b0, vec(2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 5'd1, 3'b010), "beq_taken"});
    vecs.push_back('{32'h00000063, 1'b0, 1'b0, vec(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 5'd1, 3'b010), "beq_not_taken"});
    vecs.push_back('{32'h00001063, 1'b0, 1'b0, vec(2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 5'd1, 3'b010), "bne_taken"});
    vecs.push_back('{32'h000000ef, 1'b1, 1'b1, vec(2'b01, 2'b10, 1'b0, 1'b0, 1'b1, 5'd0, 3'b011), "jal"});
    vecs.push_back('{32'h000100e7, 1'b0, 1'b1, vec(2'b10, 2'b10, 1'b0, 1'b1, 1'b1, 5'd0, 3'b000), "jalr"});
    vecs.push_back('{32'h00001037, 1'b1, 1'b0, vec(2'b00, 2'b11, 1'b0, 1'b0, 1'b1, 5'd0, 3'b100), "lui"});
    vecs.push_back('{32'h00000000, 1'b1, 1'b1, 15'd0, "illegal_zero"});
    vecs.push_back('{32'h40005093, 1'b0, 1'b0, vec(2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 5'd9, 3'b000), "srai"});
    vecs.push_back('{32'h40000093, 1'b0, 1'b0, vec(2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 5'd0, 3'b000), "addi_bit30"});
    vecs.push_back('{32'h00007063, 1'b1, 1'b0, vec(2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 5'd6, 3'b010), "bgeu_taken"});
    vecs.push_back('{32'h00002063, 1'b1, 1'b1, vec(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 5'd1, 3'b010), "branch_f3_010"});
    vecs.push_back('{32'h00000017, 1'b0, 1'b0, 15'd0, "auipc"});
    foreach (vecs[i]) begin
      @(negedge clk);
      Instr = vecs[i].ins; Zero = vecs[i].z; Negative = vecs[i].n;
      #1;
      got = observed(); checks++;
      if (got !== vecs[i].exp) begin
        errors++; $display("FAIL %s: got %h expected %h", vecs[i].name, got, vecs[i].exp);
      end
    end
  endtask

  task automatic test_random();
    logic [6:0]  ops [12] = '{7'h03, 7'h23, 7'h13, 7'h33, 7'h63, 7'h63, 7'h6f,
                              7'h67, 7'h37, 7'h17, 7'h73, 7'h0f};
    logic [6:0]  op;
    logic [14:0] got;
    logic [14:0] exp;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      op = (i % 10 == 9) ? 7'($urandom) : ops[$urandom_range(0, 11)];
      Instr    = {25'($urandom), op};
      Zero     = 1'($urandom);
      Negative = 1'($urandom);
      #1;
      exp = model(Instr[6:0], Instr[14:12], Instr[30], Zero, Negative);
      got = observed(); checks++;
      if (got !== exp) begin
        errors++; $display("FAIL random instr=%h z=%b n=%b: got %h expected %h",
                           Instr, Zero, Negative, got, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [14:0] got;
    logic [14:0] exp;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      Instr    = {25'($urandom), (i % 2 == 0) ? 7'h33 : 7'h63};
      Zero     = 1'($urandom);
      Negative = 1'($urandom);
      #1;
      exp = model(Instr[6:0], Instr[14:12], Instr[30], Zero, Negative);
      got = observed(); checks++;
      if (got !== exp) begin
        errors++; $display("FAIL back_to_back instr=%h: got %h expected %h", Instr, got, exp);
      end
    end
  endtask

  task automatic test_midrun_reset();
    logic [14:0] got;
    logic [14:0] jal_exp;
    jal_exp = vec(2'b01, 2'b10, 1'b0, 1'b0, 1'b1, 5'd0, 3'b011);
    @(negedge clk);
    Instr = 32'h000000ef; reset = 1'b1;
    #1;
    got = observed(); checks++;
    if (got !== jal_exp) begin
      errors++; $display("FAIL midrun_before_edge: got %h expected %h", got, jal_exp);
    end
    @(posedge clk); #1;
    got = observed(); checks++;
    if (got !== 15'd0) begin
      errors++; $display("FAIL midrun_reset_edge: got %h expected %h", got, 15'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    got = observed(); checks++;
    if (got !== jal_exp) begin
      errors++; $display("FAIL midrun_recover: got %h expected %h", got, jal_exp);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_midrun_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
